gcd_engine: RTL and testbench
=============================

# gcd_engine

Parametrised, self-sequenced Euclid GCD unit, the successor to the fixed 16-bit GCD datapath/controller pair. It accepts two unsigned WIDTH-bit operands with a start/ready handshake and iterates remainder steps on an internal shift-subtract modulo unit. It returns the GCD with a one-cycle valid pulse. It sits behind the top-level control and replaces the external FSM plus ALU-modulo path.

## Interface
- WIDTH, 16: operand and result width in bits, ≥ 2.
- clk  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request. Sampled only while ready_o=1.
- Zahl1_i  in  WIDTH  operand a, unsigned. Captured on an accepted start.
- Zahl2_i  in  WIDTH  operand b, unsigned. Captured on an accepted start.
- ready_o  out  1  high in IDLE only.
- valid_o  out  1  one-cycle pulse, result available.
- ergebnis_o  out  WIDTH  GCD. Registered and held until the next completion.
- err_o  out  1  pulses with valid_o when both operands are 0.
- iter_o  out  8  modulo steps used. Present only with GCD_ITER_COUNT_EN.

## Operation
- States: IDLE, CHECK, MOD_WAIT, DONE.
- **IDLE**
  - ready_o=1.
  - On start_i=1, load a_r←Zahl1_i and b_r←Zahl2_i, clear the step count, then go to CHECK.
- **CHECK**
  - If b_r==0: go to DONE.
  - Otherwise: pulse mod_start for 1 cycle with dividend a_r and divisor b_r, then go to MOD_WAIT.
- **MOD_WAIT**
  - Wait for mod_done.
  - On mod_done: a_r←b_r, b_r←rem, step count +1, go to CHECK.
- **DONE**
  - ergebnis_o←a_r, valid_o=1, err_o=(a_r==0).
  - Go to IDLE after 1 cycle.
- a<b needs no pre-swap; the first step yields rem=a, which swaps the operands.
- Zero cases:
  - gcd(x,0)=x with no modulo step.
  - gcd(0,x)=x after one step.
  - gcd(0,0)=0 with err_o=1.
- start_i outside IDLE is ignored, with no queuing.
- All arithmetic is unsigned WIDTH bits with no sign extension. The remainder is always < divisor, so there is no overflow.
- Reset values:
  - state=IDLE, ready_o=1.
  - valid_o=0, err_o=0.
  - ergebnis_o=0, iter_o=0.
  - a_r=0, b_r=0.
- Reset mid-operation aborts the computation. The modulo unit is cleared and no valid_o is issued.

## Timing
- Accepted start at edge k puts the FSM in CHECK during cycle k+1.
- Modulo unit:
  - Restoring division, 1 quotient bit per cycle.
  - mod_done is high in the WIDTH-th cycle after the mod_start cycle.
- Each Euclid step costs WIDTH+1 cycles: 1 CHECK plus WIDTH MOD_WAIT.
- Latency from start sampled to valid_o high is N·(WIDTH+1)+2 cycles, where N is the number of modulo steps.
- ready_o returns high the cycle after valid_o. The earliest next start is accepted in that cycle.
- ergebnis_o and err_o change only in DONE. err_o is 0 outside the valid_o cycle.

## Configuration
- GCD_ITER_COUNT_EN defined:
  - Adds iter_o, an 8-bit step counter.
  - The counter saturates at 255, clears on an accepted start, and is latched to the output in DONE.
  - Reset value is 0.
- GCD_ITER_COUNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package gcd_pkg holds:
  - State encodings IDLE=2'd0, CHECK=2'd1, MOD_WAIT=2'd2, DONE=2'd3.
  - ITER_W=8.
  - ITER_MAX=8'd255.
- Sub-module gcd_mod_unit, parameter WIDTH:
  - Ports: clk, rst_i, mod_start_i, dividend_i, divisor_i, rem_o, mod_done_o.
  - Contains the bit counter, partial remainder and shift register.
  - Never started with divisor 0; the FSM guards this.
- Top level gcd_engine holds the FSM, the a_r/b_r registers, the output registers and the optional counter.

## Test plan
- WIDTH=16, (48,18) → ergebnis_o=6, N=3, valid_o 53 cycles after start, iter_o=3.
- (35,0) → 35 after 2 cycles. (0,35) → 35 after 19 cycles. err_o=0 in both.
- (0,0) → ergebnis_o=0, err_o=1 for exactly the valid_o cycle, latency 2.
- (17,5) → 1 after 53 cycles. (65535,65535) → 65535 after 19 cycles.
- (48,18) start, second start (9,6) at cycle 10:
  - Second start ignored; first result 6 delivered.
  - Then (9,6) accepted after ready_o rises → 3.
- rst_i high for 1 cycle at cycle 20 of a (48,18) run → no valid_o, ready_o=1 next cycle, outputs 0. A following (12,8) → 4.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the Euclid GCD engine.
//   state_t  - controller state encoding (IDLE, CHECK, MOD_WAIT, DONE)
//   ITER_W   - width of the optional modulo-step counter
//   ITER_MAX - saturation value of that counter
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        MOD_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int          ITER_W   = 8;
    localparam logic [7:0]  ITER_MAX = 8'd255;

endpackage

// File: rtl/gcd_mod_unit.sv
// gcd_mod_unit: restoring shift-subtract modulo unit, one quotient bit per cycle.
//   clk          in   clock, rising edge
//   rst_i        in   synchronous active-high reset, aborts a running division
//   mod_start_i  in   one-cycle start pulse; dividend/divisor captured with it
//   dividend_i   in   WIDTH-bit unsigned dividend
//   divisor_i    in   WIDTH-bit unsigned divisor, never 0 when started
//   rem_o        out  remainder, valid while mod_done_o is high
//   mod_done_o   out  high in the WIDTH-th cycle after the start cycle
module gcd_mod_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             mod_start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             mod_done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The result is always
    // below the divisor, so it fits back into WIDTH bits.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] rem,
        input logic             bit_in,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] trial;
        trial = {rem, bit_in};
        if (trial >= {1'b0, dvs}) begin
            trial = trial - {1'b0, dvs};
        end
        return trial[WIDTH-1:0];
    endfunction

    // The first step is taken on the start edge itself, so the last of the
    // WIDTH steps lands on the edge that opens the done cycle and rem_o is
    // already final while mod_done_o is high.
    always_comb begin
        rem_d     = rem_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (mod_start_i) begin
            rem_d     = mod_step('0, dividend_i[WIDTH-1], divisor_i);
            shift_d   = dividend_i << 1;
            divisor_d = divisor_i;
            cnt_d     = CNT_W'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            rem_d   = mod_step(rem_q, shift_q[WIDTH-1], divisor_q);
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            done_d  = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rem_q     <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign rem_o      = rem_q;
    assign mod_done_o = done_q;

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: self-sequenced Euclid GCD unit built on gcd_mod_unit.
//   clk         in   clock, rising edge
//   rst_i       in   synchronous active-high reset, aborts a computation
//   start_i     in   request, sampled only while ready_o is high
//   Zahl1_i     in   operand a (unsigned, WIDTH bits)
//   Zahl2_i     in   operand b (unsigned, WIDTH bits)
//   ready_o     out  high in IDLE only
//   valid_o     out  one-cycle result pulse
//   ergebnis_o  out  GCD, held until the next completion
//   err_o       out  high with valid_o when both operands were 0
//   iter_o      out  modulo steps used (only with GCD_ITER_COUNT_EN)
// Optional feature macro: GCD_ITER_COUNT_EN adds the saturating step counter.
//
// Handshake: a request is accepted on a rising edge where start_i and
// ready_o are both high; start_i in any other cycle is dropped, nothing is
// queued. The result appears for exactly one cycle with valid_o, no
// back-pressure.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] ergebnis_o,
    output logic             err_o
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [ITER_W-1:0] iter_o
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] ergebnis_q, ergebnis_d;
    logic             err_q, err_d;
    logic             mod_start;
    logic [WIDTH-1:0] mod_rem;
    logic             mod_done;
`ifdef GCD_ITER_COUNT_EN
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [ITER_W-1:0] iter_q, iter_d;
`endif

    gcd_mod_unit #(
        .WIDTH(WIDTH)
    ) u_mod (
        .clk        (clk),
        .rst_i      (rst_i),
        .mod_start_i(mod_start),
        .dividend_i (a_q),
        .divisor_i  (b_q),
        .rem_o      (mod_rem),
        .mod_done_o (mod_done)
    );

    // The result registers are loaded on the edge that enters DONE, so they
    // are already visible in the valid_o cycle. err_q defaults to 0 and is
    // therefore high only during DONE.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        ergebnis_d = ergebnis_q;
        err_d      = 1'b0;
        mod_start  = 1'b0;
`ifdef GCD_ITER_COUNT_EN
        iter_cnt_d = iter_cnt_q;
        iter_d     = iter_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = Zahl1_i;
                    b_d     = Zahl2_i;
`ifdef GCD_ITER_COUNT_EN
                    iter_cnt_d = '0;
`endif
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // b==0 terminates; this also keeps a zero divisor away from
                // the modulo unit.
                if (b_q == '0) begin
                    ergebnis_d = a_q;
                    err_d      = (a_q == '0);
`ifdef GCD_ITER_COUNT_EN
                    iter_d     = iter_cnt_q;
`endif
                    state_d    = DONE;
                end else begin
                    mod_start = 1'b1;
                    state_d   = MOD_WAIT;
                end
            end
            MOD_WAIT: begin
                // a<b needs no swap: the first remainder is a itself.
                if (mod_done) begin
                    a_d = b_q;
                    b_d = mod_rem;
`ifdef GCD_ITER_COUNT_EN
                    if (iter_cnt_q != ITER_MAX) begin
                        iter_cnt_d = iter_cnt_q + ITER_W'(1);
                    end
`endif
                    state_d = CHECK;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            ergebnis_q <= '0;
            err_q      <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            iter_cnt_q <= '0;
            iter_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ergebnis_q <= ergebnis_d;
            err_q      <= err_d;
`ifdef GCD_ITER_COUNT_EN
            iter_cnt_q <= iter_cnt_d;
            iter_q     <= iter_d;
`endif
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = (state_q == DONE);
    assign ergebnis_o = ergebnis_q;
    assign err_o      = err_q;
`ifdef GCD_ITER_COUNT_EN
    assign iter_o     = iter_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed bench for gcd_engine at WIDTH=16.
// Expected GCDs, step counts and latencies (N*(WIDTH+1)+2) are hand-computed.
module tb_gcd_engine;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] Zahl1_i;
    logic [WIDTH-1:0] Zahl2_i;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] ergebnis_o;
    logic             err_o;
`ifdef GCD_ITER_COUNT_EN
    logic [7:0]       iter_o;
`endif

    int checks;
    int errors;

    gcd_engine #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .Zahl1_i   (Zahl1_i),
        .Zahl2_i   (Zahl2_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .ergebnis_o(ergebnis_o),
        .err_o     (err_o)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_o    (iter_o)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, 32'(ready_o), 32'd1);
    endtask

    // Issue one request and follow it to valid_o. Optionally drive a second
    // (to-be-ignored) start in cycle icyc after acceptance.
    task automatic run_gcd(input string tag,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int exp_res, input int exp_lat, input int exp_err,
                           input int exp_iter,
                           input int icyc, input logic [WIDTH-1:0] ia,
                           input logic [WIDTH-1:0] ib);
        int  cyc;
        bit  got;
        wait_ready(tag);
        start_i = 1'b1;
        Zahl1_i = a;
        Zahl2_i = b;
        tick();                     // accepting edge; now in cycle 1
        start_i = 1'b0;
        check({tag, "_busy"}, 32'(ready_o), 32'd0);
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 300) begin
            start_i = (cyc == icyc);
            if (cyc == icyc) begin
                Zahl1_i = ia;
                Zahl2_i = ib;
            end
            if (valid_o === 1'b1) begin
                got = 1'b1;
            end else begin
                tick();
                cyc++;
            end
        end
        start_i = 1'b0;
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_result"}, 32'(ergebnis_o), 32'(exp_res));
        check({tag, "_err"}, 32'(err_o), 32'(exp_err));
`ifdef GCD_ITER_COUNT_EN
        check({tag, "_iter"}, 32'(iter_o), 32'(exp_iter));
`else
        if (exp_iter < 0) $display("note: negative iteration count for %s", tag);
`endif
        tick();
        check({tag, "_pulse_end"}, 32'(valid_o), 32'd0);
        check({tag, "_ready_back"}, 32'(ready_o), 32'd1);
        check({tag, "_err_clear"}, 32'(err_o), 32'd0);
        check({tag, "_held"}, 32'(ergebnis_o), 32'(exp_res));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        checks  = 0;
        errors  = 0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        Zahl1_i = '0;
        Zahl2_i = '0;
        tick();
        tick();
        rst_i = 1'b0;

        // reset state
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_result", 32'(ergebnis_o), 32'd0);
`ifdef GCD_ITER_COUNT_EN
        check("rst_iter", 32'(iter_o), 32'd0);
`endif

        // main function and zero cases
        run_gcd("g48_18", 16'd48, 16'd18, 6, 53, 0, 3, -1, '0, '0);
        run_gcd("g35_0", 16'd35, 16'd0, 35, 2, 0, 0, -1, '0, '0);
        run_gcd("g0_35", 16'd0, 16'd35, 35, 19, 0, 1, -1, '0, '0);
        run_gcd("g0_0", 16'd0, 16'd0, 0, 2, 1, 0, -1, '0, '0);
        run_gcd("g17_5", 16'd17, 16'd5, 1, 53, 0, 3, -1, '0, '0);
        run_gcd("gmax", 16'hFFFF, 16'hFFFF, 65535, 19, 0, 1, -1, '0, '0);
        run_gcd("g8_12", 16'd8, 16'd12, 4, 53, 0, 3, -1, '0, '0);

        // start while busy is ignored, then accepted once idle
        run_gcd("g48_18_busy", 16'd48, 16'd18, 6, 53, 0, 3, 10, 16'd9, 16'd6);
        run_gcd("g9_6", 16'd9, 16'd6, 3, 36, 0, 2, -1, '0, '0);

        // reset mid-operation
        wait_ready("abort");
        start_i = 1'b1;
        Zahl1_i = 16'd48;
        Zahl2_i = 16'd18;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_result", 32'(ergebnis_o), 32'd0);
        check("abort_err", 32'(err_o), 32'd0);
`ifdef GCD_ITER_COUNT_EN
        check("abort_iter", 32'(iter_o), 32'd0);
`endif
        seen = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            if (valid_o === 1'b1) seen = 1'b1;
            tick();
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run_gcd("g12_8", 16'd12, 16'd8, 4, 36, 0, 2, -1, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
